output_arbiter: RTL and testbench

OUTPUT_ARBITER -- requirements
Module: output_arbiter

---
 rtl/output_arbiter.sv | 113 +++++++++++
 tb/tb_output_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/output_arbiter.sv
// Output-port arbiter for one router output.
// Picks one requesting input round-robin, holds the crossbar for that input
// until its TAIL flit has crossed, and gates every flit on a downstream credit.
module output_arbiter #(
    parameter int          CREDIT_DEPTH = 4,
    parameter int          CNT_W        = 3,
    parameter logic [2:0]  TAIL_ID      = 3'b100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       req,
    input  logic [4:0]       empty_in,
    input  logic [14:0]      flit_id_in,
    input  logic             credit_in,
    output logic [4:0]       grant,
    output logic [4:0]       rd_en,
    output logic [2:0]       xbar_sel,
    output logic             valid_out,
    output logic [CNT_W-1:0] credit_cnt
);

    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDIT_DEPTH);
    localparam logic [2:0]       SEL_NONE = 3'd7;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           r_state;
    logic [4:0]       r_grant;
    logic [2:0]       r_xbar_sel;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_credit;

    logic [2:0]       w_pick;
    logic [4:0]       w_pick_oh;
    logic             w_tail;
    logic             w_xfer;

    // Round-robin search starting one past the last served input, wrapping at 4.
    function automatic logic [2:0] rr_pick(input logic [4:0] rq, input logic [2:0] ptr);
        logic [2:0] idx;
        int         p;
        rr_pick = SEL_NONE;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = 5; k >= 1; k--) begin
            p   = (int'(ptr) + k) % 5;
            idx = p[2:0];
            if (rq[idx]) rr_pick = idx;
        end
    endfunction

    assign w_pick    = rr_pick(req, r_ptr);
    assign w_pick_oh = 5'b00001 << w_pick;

    // Decode whether the granted input is presenting its TAIL flit.
    always_comb begin
        w_tail = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (r_grant[i] && (flit_id_in[3*i +: 3] == TAIL_ID)) w_tail = 1'b1;
        end
    end

    // A flit moves only while locked, the owner FIFO has data and a credit is left.
    assign w_xfer = (r_state == LOCKED) && !rst &&
                    ((empty_in & r_grant) == 5'b00000) && (r_credit != '0);

    assign rd_en      = w_xfer ? r_grant : 5'b00000;
    assign valid_out  = w_xfer;
    assign grant      = r_grant;
    assign xbar_sel   = r_xbar_sel;
    assign credit_cnt = r_credit;

    // Arbitration FSM: grant on request in IDLE, release after the TAIL transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= 5'b00000;
            r_xbar_sel <= SEL_NONE;
            r_ptr      <= 3'd4;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req != 5'b00000) begin
                        r_grant    <= w_pick_oh;
                        r_xbar_sel <= w_pick;
                        r_state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    // The cycle back in IDLE is the bubble before the next grant.
                    if (w_xfer && w_tail) begin
                        r_grant    <= 5'b00000;
                        r_xbar_sel <= SEL_NONE;
                        r_ptr      <= r_xbar_sel;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Credit counter: consume on transfer, refill on credit_in, saturate at depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= CRED_MAX;
        end else if (w_xfer && !credit_in) begin
            r_credit <= r_credit - 1'b1;
        end else if (credit_in && !w_xfer && (r_credit != CRED_MAX)) begin
            r_credit <= r_credit + 1'b1;
        end
    end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: each step drives inputs, queues the
// outputs expected after the next rising edge, then pops and compares them.
module tb_output_arbiter;

    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] P = 3'b010;
    localparam logic [2:0] T = 3'b100;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [4:0]  empty_in;
    logic [14:0] flit_id_in;
    logic        credit_in;
    logic [4:0]  grant;
    logic [4:0]  rd_en;
    logic [2:0]  xbar_sel;
    logic        valid_out;
    logic [2:0]  credit_cnt;

    typedef struct {
        string      tag;
        logic [4:0] g;
        logic [4:0] rd;
        logic [2:0] xs;
        logic       v;
        logic [2:0] cc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    output_arbiter #(.CREDIT_DEPTH(4), .CNT_W(3), .TAIL_ID(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .empty_in   (empty_in),
        .flit_id_in (flit_id_in),
        .credit_in  (credit_in),
        .grant      (grant),
        .rd_en      (rd_en),
        .xbar_sel   (xbar_sel),
        .valid_out  (valid_out),
        .credit_cnt (credit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input string tag, input logic r, input logic [4:0] rq,
                        input logic [4:0] em, input logic [2:0] fid, input logic ci,
                        input logic [4:0] eg, input logic [4:0] erd, input logic [2:0] exs,
                        input logic ev, input logic [2:0] ecc);
        exp_t e;
        rst        = r;
        req        = rq;
        empty_in   = em;
        flit_id_in = {5{fid}};
        credit_in  = ci;
        e.tag = tag; e.g = eg; e.rd = erd; e.xs = exs; e.v = ev; e.cc = ecc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard: got empty queue expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (grant === e.g) else begin
                errors++; $error("FAIL %s grant: got %b expected %b", e.tag, grant, e.g);
            end
            checks++;
            assert (rd_en === e.rd) else begin
                errors++; $error("FAIL %s rd_en: got %b expected %b", e.tag, rd_en, e.rd);
            end
            checks++;
            assert (xbar_sel === e.xs) else begin
                errors++; $error("FAIL %s xbar_sel: got %0d expected %0d", e.tag, xbar_sel, e.xs);
            end
            checks++;
            assert (valid_out === e.v) else begin
                errors++; $error("FAIL %s valid_out: got %b expected %b", e.tag, valid_out, e.v);
            end
            checks++;
            assert (credit_cnt === e.cc) else begin
                errors++; $error("FAIL %s credit_cnt: got %0d expected %0d", e.tag, credit_cnt, e.cc);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; empty_in = '0; flit_id_in = '0; credit_in = 1'b0;
        //      tag          rst req       empty     fid ci   grant     rd_en     xs  v  cc
        // Reset state, request present but ignored while in reset.
        step("rst0",        1, 5'b00001, 5'b00000, P, 0,  5'b00000, 5'b00000, 7, 0, 4);
        step("rst1",        1, 5'b00000, 5'b00000, P, 0,  5'b00000, 5'b00000, 7, 0, 4);
        // Single 4-flit packet from N, no credits returned.
        step("n_grant",     0, 5'b00001, 5'b00000, H, 0,  5'b00001, 5'b00001, 0, 1, 4);
        step("n_hdr",       0, 5'b00001, 5'b00000, H, 0,  5'b00001, 5'b00001, 0, 1, 3);
        step("n_p1",        0, 5'b00001, 5'b00000, P, 0,  5'b00001, 5'b00001, 0, 1, 2);
        step("n_p2",        0, 5'b00001, 5'b00000, P, 0,  5'b00001, 5'b00001, 0, 1, 1);
        step("n_tail",      0, 5'b00001, 5'b00000, T, 0,  5'b00000, 5'b00000, 7, 0, 0);
        step("rstA",        1, 5'b00000, 5'b00000, P, 0,  5'b00000, 5'b00000, 7, 0, 4);
        // Idle with no request; credit_in at full count saturates.
        step("sat",         0, 5'b00000, 5'b00000, P, 1,  5'b00000, 5'b00000, 7, 0, 4);
        // Round robin: E then bubble then L then E.
        step("rr_e",        0, 5'b10010, 5'b00000, H, 0,  5'b00010, 5'b00010, 1, 1, 4);
        step("rr_e_hdr",    0, 5'b10010, 5'b00000, H, 0,  5'b00010, 5'b00010, 1, 1, 3);
        step("rr_e_tail",   0, 5'b10010, 5'b00000, T, 0,  5'b00000, 5'b00000, 7, 0, 2);
        step("rr_l",        0, 5'b10010, 5'b00000, H, 0,  5'b10000, 5'b10000, 4, 1, 2);
        step("rr_l_hdr",    0, 5'b10010, 5'b00000, H, 0,  5'b10000, 5'b10000, 4, 1, 1);
        step("rr_l_tail",   0, 5'b10010, 5'b00000, T, 0,  5'b00000, 5'b00000, 7, 0, 0);
        step("cred_idle",   0, 5'b00000, 5'b00000, P, 1,  5'b00000, 5'b00000, 7, 0, 1);
        step("rr_e2",       0, 5'b10010, 5'b00000, H, 1,  5'b00010, 5'b00010, 1, 1, 2);
        // Transfer and credit in the same cycle leave the count unchanged.
        step("xfer_cred",   0, 5'b10010, 5'b00000, P, 1,  5'b00010, 5'b00010, 1, 1, 2);
        step("e2_tail",     0, 5'b10010, 5'b00000, T, 0,  5'b00000, 5'b00000, 7, 0, 1);
        step("rstB",        1, 5'b00000, 5'b00000, P, 0,  5'b00000, 5'b00000, 7, 0, 4);
        // 6-flit W packet with no credits: 4 flits, stall, one credit -> one flit.
        step("w_grant",     0, 5'b00100, 5'b00000, H, 0,  5'b00100, 5'b00100, 2, 1, 4);
        step("w_f1",        0, 5'b00100, 5'b00000, H, 0,  5'b00100, 5'b00100, 2, 1, 3);
        step("w_f2",        0, 5'b00100, 5'b00000, P, 0,  5'b00100, 5'b00100, 2, 1, 2);
        step("w_f3",        0, 5'b00100, 5'b00000, P, 0,  5'b00100, 5'b00100, 2, 1, 1);
        step("w_f4",        0, 5'b00100, 5'b00000, P, 0,  5'b00100, 5'b00000, 2, 0, 0);
        step("w_stall",     0, 5'b00100, 5'b00000, P, 0,  5'b00100, 5'b00000, 2, 0, 0);
        step("w_credit",    0, 5'b00100, 5'b00000, P, 1,  5'b00100, 5'b00100, 2, 1, 1);
        step("w_f5",        0, 5'b00100, 5'b00000, P, 0,  5'b00100, 5'b00000, 2, 0, 0);
        step("w_stall2",    0, 5'b00100, 5'b00000, P, 0,  5'b00100, 5'b00000, 2, 0, 0);
        step("rstC",        1, 5'b00000, 5'b00000, P, 0,  5'b00000, 5'b00000, 7, 0, 4);
        // Empty owner FIFO mid-packet stalls with lock held.
        step("e_grant",     0, 5'b00001, 5'b00000, H, 0,  5'b00001, 5'b00001, 0, 1, 4);
        step("e_hdr",       0, 5'b00001, 5'b00000, H, 0,  5'b00001, 5'b00001, 0, 1, 3);
        step("e_empty1",    0, 5'b00001, 5'b00001, P, 0,  5'b00001, 5'b00000, 0, 0, 3);
        step("e_empty2",    0, 5'b00001, 5'b00001, P, 0,  5'b00001, 5'b00000, 0, 0, 3);
        step("e_empty3",    0, 5'b00011, 5'b00001, H, 0,  5'b00001, 5'b00000, 0, 0, 3);
        step("e_resume",    0, 5'b00001, 5'b00000, P, 0,  5'b00001, 5'b00001, 0, 1, 2);
        step("e_tail",      0, 5'b00001, 5'b00000, T, 0,  5'b00000, 5'b00000, 7, 0, 1);
        step("rstD",        1, 5'b00000, 5'b00000, P, 0,  5'b00000, 5'b00000, 7, 0, 4);
        // Reset mid-packet drops the lock; priority restarts at N.
        step("m_grant",     0, 5'b00100, 5'b00000, H, 0,  5'b00100, 5'b00100, 2, 1, 4);
        step("m_hdr",       0, 5'b00100, 5'b00000, H, 0,  5'b00100, 5'b00100, 2, 1, 3);
        step("m_rst",       1, 5'b00100, 5'b00000, P, 0,  5'b00000, 5'b00000, 7, 0, 4);
        step("m_all",       0, 5'b11111, 5'b00000, H, 0,  5'b00001, 5'b00001, 0, 1, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
